// File: rtl/idma_desc64_reg_submitter.sv
// Purpose: submits 64-bit descriptor addresses to a desc64 frontend via regbus writes to DESC_ADDR (optional stall timeout: IDMA_DESC64_SUBMIT_TIMEOUT_EN).
// Latency: request valid one cycle after stream accept; back-to-back completions sustain one write per cycle.
// Backpressure: regbus !ready holds the request and deasserts desc_ready_o; a write error parks in ERROR until err_clear_i.

package idma_desc64_reg_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module idma_desc64_reg_submitter #(
    parameter int unsigned          DataWidth      = 64,
    parameter int unsigned          AddrWidth      = 32,
    parameter logic [AddrWidth-1:0] DescAddrOffset = '0,
    parameter int unsigned          CntWidth       = 32,
    parameter int unsigned          TimeoutCycles  = 1024,
    parameter type                  reg_req_t      = idma_desc64_reg_pkg::reg_req_t,
    parameter type                  reg_rsp_t      = idma_desc64_reg_pkg::reg_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [63:0]          desc_addr_i,
    input  logic                 desc_valid_i,
    output logic                 desc_ready_o,
    output reg_req_t             reg_req_o,
    input  reg_rsp_t             reg_rsp_i,
    output logic                 busy_o,
    output logic                 error_o,
    output logic [63:0]          err_addr_o,
    input  logic                 err_clear_i,
`ifdef IDMA_DESC64_SUBMIT_TIMEOUT_EN
    output logic                 timeout_o,
`endif
    output logic [CntWidth-1:0]  submitted_o
);

    // The descriptor address is written as one full regbus beat.
    if (DataWidth != 64) begin : g_bad_width
        $error("idma_desc64_reg_submitter: DataWidth must be 64");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ERROR = 2'd2
    } state_e;

    state_e               state, state_nxt;
    logic [AddrWidth-1:0] req_addr;
    logic [63:0]          req_wdata;
    logic                 accept;
    logic                 done_ok;
    logic                 done_err;
    logic                 unused_rdata;

    // Read data is never consumed by a write-only initiator.
    assign unused_rdata = ^reg_rsp_i.rdata;

    assign done_ok  = (state == WRITE) && reg_rsp_i.ready && !reg_rsp_i.error;
    assign done_err = (state == WRITE) && reg_rsp_i.ready &&  reg_rsp_i.error;

    // A new descriptor may enter when idle or when the current write retires cleanly.
    assign desc_ready_o = (state == IDLE) || done_ok;
    assign accept       = desc_valid_i && desc_ready_o;
    assign busy_o       = (state == WRITE);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = WRITE;
            end
            WRITE: begin
                if (done_err)     state_nxt = ERROR;
                else if (done_ok) state_nxt = accept ? WRITE : IDLE;
            end
            ERROR: begin
                if (err_clear_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields captured on accept; held while the frontend stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (accept) begin
            req_addr  <= base_addr_i + DescAddrOffset;
            req_wdata <= desc_addr_i;
        end
    end

    // Drive the regbus request; valid follows the registered state only.
    always_comb begin
        reg_req_o       = '0;
        reg_req_o.addr  = req_addr;
        reg_req_o.write = 1'b1;
        reg_req_o.wdata = req_wdata;
        reg_req_o.wstrb = '1;
        reg_req_o.valid = (state == WRITE);
    end

    // Sticky error capture; the failed descriptor is dropped, its address kept for software.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            error_o    <= 1'b0;
            err_addr_o <= '0;
        end else if (done_err) begin
            error_o    <= 1'b1;
            err_addr_o <= req_wdata;
        end else if ((state == ERROR) && err_clear_i) begin
            error_o    <= 1'b0;
        end
    end

    // Count successful writes, wrapping naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            submitted_o <= '0;
        end else if (done_ok) begin
            submitted_o <= submitted_o + 1'b1;
        end
    end

`ifdef IDMA_DESC64_SUBMIT_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(TimeoutCycles + 1);
    localparam logic [StallW-1:0] StallMax = StallW'(TimeoutCycles);

    logic [StallW-1:0] stall_cnt;
    logic [StallW-1:0] stall_nxt;

    // Saturating count of consecutive stalled write cycles.
    always_comb begin
        stall_nxt = '0;
        if ((state == WRITE) && !reg_rsp_i.ready) begin
            stall_nxt = (stall_cnt == StallMax) ? stall_cnt : stall_cnt + 1'b1;
        end
    end

    // Stall counter and sticky timeout flag; the request itself is never aborted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            timeout_o <= 1'b0;
        end else begin
            stall_cnt <= stall_nxt;
            if (err_clear_i) begin
                timeout_o <= 1'b0;
            end else if (stall_nxt >= StallMax) begin
                timeout_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_idma_desc64_reg_submitter.sv
// Directed bench for idma_desc64_reg_submitter: single write, back-to-back burst,
// long stall, error/clear, reset mid-write and (when enabled) stall timeout.
module tb_idma_desc64_reg_submitter;
    import idma_desc64_reg_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] base_addr;
    logic [63:0] desc_addr;
    logic        desc_valid;
    logic        desc_ready;
    reg_req_t    reg_req;
    reg_rsp_t    reg_rsp;
    logic        busy;
    logic        error;
    logic [63:0] err_addr;
    logic        err_clear;
    logic [31:0] submitted;
`ifdef IDMA_DESC64_SUBMIT_TIMEOUT_EN
    logic        timeout;
`endif

    int n_total = 0;
    int n_bad   = 0;

    idma_desc64_reg_submitter #(
        .DataWidth      (64),
        .AddrWidth      (32),
        .DescAddrOffset (32'h8),
        .CntWidth       (32),
        .TimeoutCycles  (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .base_addr_i  (base_addr),
        .desc_addr_i  (desc_addr),
        .desc_valid_i (desc_valid),
        .desc_ready_o (desc_ready),
        .reg_req_o    (reg_req),
        .reg_rsp_i    (reg_rsp),
        .busy_o       (busy),
        .error_o      (error),
        .err_addr_o   (err_addr),
        .err_clear_i  (err_clear),
`ifdef IDMA_DESC64_SUBMIT_TIMEOUT_EN
        .timeout_o    (timeout),
`endif
        .submitted_o  (submitted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic [63:0] burst [4];

    initial begin
        burst[0] = 64'h0000_0001_0000_1000;
        burst[1] = 64'h0000_0001_0000_2000;
        burst[2] = 64'h0000_0001_0000_3000;
        burst[3] = 64'h0000_0001_0000_4000;

        rst        = 1'b1;
        base_addr  = 32'h1000;
        desc_addr  = '0;
        desc_valid = 1'b0;
        err_clear  = 1'b0;
        reg_rsp    = '0;
        step();
        // Reset values
        chk("rst_valid",     64'(reg_req.valid), 64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_error",     64'(error),         64'd0);
        chk("rst_err_addr",  err_addr,           64'd0);
        chk("rst_submitted", 64'(submitted),     64'd0);
        chk("rst_ready",     64'(desc_ready),    64'd1);
`ifdef IDMA_DESC64_SUBMIT_TIMEOUT_EN
        chk("rst_timeout",   64'(timeout),       64'd0);
`endif
        rst = 1'b0;
        step();

        // 1. single write
        reg_rsp.ready = 1'b1;
        desc_addr  = 64'hDEAD_BEEF_0000_0040;
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        chk("t1_valid", 64'(reg_req.valid), 64'd1);
        chk("t1_write", 64'(reg_req.write), 64'd1);
        chk("t1_addr",  64'(reg_req.addr),  64'h1008);
        chk("t1_wdata", reg_req.wdata,      64'hDEAD_BEEF_0000_0040);
        chk("t1_wstrb", 64'(reg_req.wstrb), 64'hFF);
        chk("t1_busy",  64'(busy),          64'd1);
        step();
        chk("t1_idle_valid", 64'(reg_req.valid), 64'd0);
        chk("t1_submitted",  64'(submitted),     64'd1);

        // 2. four back-to-back writes, one per cycle
        desc_valid = 1'b1;
        desc_addr  = burst[0];
        for (int i = 0; i < 4; i++) begin
            step();
            if (i < 3) desc_addr = burst[i+1];
            else       desc_valid = 1'b0;
            chk("t2_valid", 64'(reg_req.valid), 64'd1);
            chk("t2_wdata", reg_req.wdata,      burst[i]);
        end
        step();
        chk("t2_idle_valid", 64'(reg_req.valid), 64'd0);
        chk("t2_submitted",  64'(submitted),     64'd5);

        // 3. long stall
        reg_rsp.ready = 1'b0;
        base_addr  = 32'h2000;
        desc_addr  = 64'h0000_0000_CAFE_0100;
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        base_addr  = 32'h3000;
        for (int i = 0; i < 20; i++) begin
            chk("t3_valid", 64'(reg_req.valid), 64'd1);
            chk("t3_addr",  64'(reg_req.addr),  64'h2008);
            chk("t3_wdata", reg_req.wdata,      64'h0000_0000_CAFE_0100);
            chk("t3_ready", 64'(desc_ready),    64'd0);
            chk("t3_busy",  64'(busy),          64'd1);
            step();
        end
        chk("t3_cnt_stalled", 64'(submitted), 64'd5);
        reg_rsp.ready = 1'b1;
        step();
        chk("t3_done_valid", 64'(reg_req.valid), 64'd0);
        chk("t3_submitted",  64'(submitted),     64'd6);

        // 4. error completion
        reg_rsp.error = 1'b1;
        desc_addr  = 64'h80;
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        chk("t4_ready_err", 64'(desc_ready), 64'd0);
        step();
        desc_addr  = 64'h90;
        desc_valid = 1'b1;
        chk("t4_error",     64'(error),         64'd1);
        chk("t4_err_addr",  err_addr,           64'h80);
        chk("t4_ready",     64'(desc_ready),    64'd0);
        chk("t4_valid",     64'(reg_req.valid), 64'd0);
        chk("t4_busy",      64'(busy),          64'd0);
        chk("t4_submitted", 64'(submitted),     64'd6);
        step();
        chk("t4_parked", 64'(error), 64'd1);
        desc_valid = 1'b0;
        reg_rsp.error = 1'b0;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("t4_clr_error",    64'(error),      64'd0);
        chk("t4_clr_err_addr", err_addr,        64'h80);
        chk("t4_clr_ready",    64'(desc_ready), 64'd1);
        desc_addr  = 64'hC0;
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        chk("t4_next_wdata", reg_req.wdata, 64'hC0);
        step();
        chk("t4_next_submitted", 64'(submitted), 64'd7);

        // 5. reset while a write is stalled
        reg_rsp.ready = 1'b0;
        desc_addr  = 64'hE0;
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        step();
        chk("t5_busy_pre", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_valid",     64'(reg_req.valid), 64'd0);
        chk("t5_busy",      64'(busy),          64'd0);
        chk("t5_error",     64'(error),         64'd0);
        chk("t5_err_addr",  err_addr,           64'd0);
        chk("t5_submitted", 64'(submitted),     64'd0);
        chk("t5_ready",     64'(desc_ready),    64'd1);
        step();
        rst = 1'b0;
        step();

`ifdef IDMA_DESC64_SUBMIT_TIMEOUT_EN
        // 6. stall timeout at 8 cycles, request kept alive
        desc_addr  = 64'hF0;
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("t6_no_timeout_7", 64'(timeout), 64'd0);
        step();
        chk("t6_timeout",   64'(timeout),       64'd1);
        chk("t6_valid",     64'(reg_req.valid), 64'd1);
        chk("t6_wdata",     reg_req.wdata,      64'hF0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("t6_cleared",   64'(reg_req.valid), 64'd1);
        chk("t6_clr_flag",  64'(timeout),       64'd0);
        reg_rsp.ready = 1'b1;
        step();
        chk("t6_submitted", 64'(submitted), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
